// File: rtl/memctrl_if.sv
// rtl/memctrl_if.sv - memory bus request/response signal bundle for memctrl
interface memctrl_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/memctrl.sv
// rtl/memctrl.sv - load/store unit bridging the execute stage to a req/gnt/rvalid memory bus
module memctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_raddr_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [1:0]  byte_sel_i,
    input  logic        un_sign_i,
    input  logic [4:0]  rd_waddr_i,
    memctrl_if.master   bus,
    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_wdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        err_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [1:0]    bsel_q, bsel_d;
    logic          uns_q, uns_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        req_any, misal, accept, in_idle, in_req, busy, timeout;
    logic [31:0] req_addr, st_data, sh_data, ld_data;
    logic [3:0]  st_strb;
    logic [15:0] ld_h;

    assign req_any  = mem_re_i | mem_we_i;
    assign req_addr = mem_re_i ? mem_raddr_i : mem_waddr_i;
    assign misal    = (byte_sel_i == 2'b11) ||
                      (byte_sel_i == 2'b01 && req_addr[0]) ||
                      (byte_sel_i == 2'b10 && req_addr[1:0] != 2'b00);
    assign in_idle  = (state_q == S_IDLE);
    assign in_req   = (state_q == S_REQ);
    assign busy     = in_req || (state_q == S_WAIT);
    assign accept   = in_idle && req_any && !misal;
    // Abort takes priority over a handshake arriving in the same cycle.
    assign timeout  = busy && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
        st_strb = 4'b1111;
        st_data = mem_wdata_i;
        case (byte_sel_i)
            2'b00: begin
                st_strb = 4'b0001 << req_addr[1:0];
                st_data = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << req_addr[1:0];
                st_data = {2{mem_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        bsel_d  = bsel_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_REQ;
                addr_d  = req_addr;
                we_d    = !mem_re_i;
                bsel_d  = byte_sel_i;
                uns_d   = un_sign_i;
                rd_d    = rd_waddr_i;
                wdata_d = mem_re_i ? 32'd0 : st_data;
                wstrb_d = mem_re_i ? 4'd0 : st_strb;
                cnt_d   = '0;
            end
            S_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (timeout)            state_d = S_IDLE;
                else if (bus.bus_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (timeout) state_d = S_IDLE;
                else if (bus.bus_rvalid_i) begin
                    state_d = S_DONE;
                    if (!we_q) rdata_d = bus.bus_rdata_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            bsel_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            bsel_q  <= bsel_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sh_data = rdata_q >> {addr_q[1:0], 3'b000};
    assign ld_h    = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        ld_data = rdata_q;
        case (bsel_q)
            2'b00:   ld_data = {{24{!uns_q && sh_data[7]}}, sh_data[7:0]};
            2'b01:   ld_data = {{16{!uns_q && ld_h[15]}}, ld_h};
            default: ;
        endcase
    end

    assign bus.bus_req_o   = in_req && !timeout;
    assign bus.bus_we_o    = in_req && we_q;
    assign bus.bus_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.bus_wdata_o = in_req ? wdata_q : 32'd0;
    assign bus.bus_wstrb_o = in_req ? wstrb_q : 4'd0;

    assign rd_we_o    = (state_q == S_DONE) && !we_q && (rd_q != 5'd0);
    assign rd_waddr_o = rd_we_o ? rd_q : 5'd0;
    assign rd_wdata_o = rd_we_o ? ld_data : 32'd0;

    // Combinational request-side outputs are masked while reset is held.
    assign stall_o    = rst && ((busy && !timeout) || accept);
    assign misalign_o = rst && in_idle && req_any && misal;
    assign err_o      = rst && (timeout || (accept && mem_re_i && mem_we_i));
endmodule

// File: tb/tb_memctrl.sv
// tb/tb_memctrl.sv - directed self-checking bench for memctrl
module tb_memctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_re_i, mem_we_i, un_sign_i;
    logic [31:0] mem_raddr_i, mem_waddr_i, mem_wdata_i;
    logic [1:0]  byte_sel_i;
    logic [4:0]  rd_waddr_i;
    logic        rd_we_o, stall_o, misalign_o, err_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_wdata_o;
    int          errors = 0;
    int          checks = 0;

    memctrl_if bif();

    memctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_re_i    (mem_re_i),
        .mem_we_i    (mem_we_i),
        .mem_raddr_i (mem_raddr_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .byte_sel_i  (byte_sel_i),
        .un_sign_i   (un_sign_i),
        .rd_waddr_i  (rd_waddr_i),
        .bus         (bif),
        .rd_we_o     (rd_we_o),
        .rd_waddr_o  (rd_waddr_o),
        .rd_wdata_o  (rd_wdata_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"}, 32'(bif.bus_req_o), 32'd0);
        check({tag, "_bus_we"}, 32'(bif.bus_we_o), 32'd0);
        check({tag, "_bus_addr"}, bif.bus_addr_o, 32'd0);
        check({tag, "_bus_wdata"}, bif.bus_wdata_o, 32'd0);
        check({tag, "_bus_wstrb"}, 32'(bif.bus_wstrb_o), 32'd0);
        check({tag, "_rd_we"}, 32'(rd_we_o), 32'd0);
        check({tag, "_rd_waddr"}, 32'(rd_waddr_o), 32'd0);
        check({tag, "_rd_wdata"}, rd_wdata_o, 32'd0);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_misalign"}, 32'(misalign_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    task automatic set_req(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] bs,
                           input logic us, input logic [4:0] rd);
        mem_re_i = re;   mem_we_i = we;
        mem_raddr_i = addr; mem_waddr_i = addr;
        mem_wdata_i = wd; byte_sel_i = bs; un_sign_i = us; rd_waddr_i = rd;
    endtask

    initial begin
        rst = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0);
        bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b0; bif.bus_rdata_i = 32'd0;
        tick(); tick(); smp();
        check_all_zero("reset");
        tick(); rst = 1'b1;

        // Signed byte load, zero-wait bus: rd_we_o three cycles after the request.
        tick(); set_req(1'b1, 1'b0, 32'h0000_1003, 32'd0, 2'b00, 1'b0, 5'd5);
        smp(); check("lb_stall_idle", 32'(stall_o), 32'd1);
        tick(); bif.bus_gnt_i = 1'b1;
        smp(); check("lb_req", 32'(bif.bus_req_o), 32'd1);
               check("lb_addr", bif.bus_addr_o, 32'h0000_1000);
               check("lb_we", 32'(bif.bus_we_o), 32'd0);
        tick(); bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'h80FF_1234;
        smp(); check("lb_req_drop", 32'(bif.bus_req_o), 32'd0);
               check("lb_stall_wait", 32'(stall_o), 32'd1);
        tick(); bif.bus_rvalid_i = 1'b0;
        smp(); check("lb_rd_we", 32'(rd_we_o), 32'd1);
               check("lb_rd_waddr", 32'(rd_waddr_o), 32'd5);
               check("lb_rd_wdata", rd_wdata_o, 32'hFFFF_FF80);
               check("lb_stall_done", 32'(stall_o), 32'd0);
        tick(); mem_re_i = 1'b0;

        // Halfword store to upper lane.
        tick(); set_req(1'b0, 1'b1, 32'h0000_2002, 32'h0000_ABCD, 2'b01, 1'b0, 5'd0);
        smp(); check("sh_stall", 32'(stall_o), 32'd1);
        tick(); bif.bus_gnt_i = 1'b1;
        smp(); check("sh_we", 32'(bif.bus_we_o), 32'd1);
               check("sh_strb", 32'(bif.bus_wstrb_o), 32'hC);
               check("sh_wdata", bif.bus_wdata_o, 32'hABCD_ABCD);
               check("sh_addr", bif.bus_addr_o, 32'h0000_2000);
        tick(); bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b1;
        smp(); check("sh_rd_we_wait", 32'(rd_we_o), 32'd0);
        tick(); bif.bus_rvalid_i = 1'b0;
        smp(); check("sh_rd_we_done", 32'(rd_we_o), 32'd0);
               check("sh_stall_done", 32'(stall_o), 32'd0);
        tick(); mem_we_i = 1'b0;

        // Misaligned word load.
        tick(); set_req(1'b1, 1'b0, 32'h0000_3001, 32'd0, 2'b10, 1'b0, 5'd3);
        smp(); check("mis_pulse", 32'(misalign_o), 32'd1);
               check("mis_stall", 32'(stall_o), 32'd0);
               check("mis_req", 32'(bif.bus_req_o), 32'd0);
        tick(); mem_re_i = 1'b0;
        smp(); check("mis_pulse_end", 32'(misalign_o), 32'd0);
               check("mis_req_after", 32'(bif.bus_req_o), 32'd0);

        // Unsigned halfword load, grant delayed 4 cycles, rvalid 2 cycles after grant.
        tick(); set_req(1'b1, 1'b0, 32'h0000_4006, 32'd0, 2'b01, 1'b1, 5'd7);
        smp(); check("dly_stall_idle", 32'(stall_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); smp();
            check("dly_req_hold", 32'(bif.bus_req_o), 32'd1);
            check("dly_addr_hold", bif.bus_addr_o, 32'h0000_4004);
            check("dly_stall_req", 32'(stall_o), 32'd1);
        end
        tick(); bif.bus_gnt_i = 1'b1;
        smp(); check("dly_req_gnt", 32'(bif.bus_req_o), 32'd1);
               check("dly_addr_gnt", bif.bus_addr_o, 32'h0000_4004);
        tick(); bif.bus_gnt_i = 1'b0;
        smp(); check("dly_req_drop", 32'(bif.bus_req_o), 32'd0);
               check("dly_stall_w1", 32'(stall_o), 32'd1);
               check("dly_rdwe_w1", 32'(rd_we_o), 32'd0);
        tick(); bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'h9876_5432;
        smp(); check("dly_stall_w2", 32'(stall_o), 32'd1);
        tick(); bif.bus_rvalid_i = 1'b0;
        smp(); check("dly_rd_we", 32'(rd_we_o), 32'd1);
               check("dly_rd_waddr", 32'(rd_waddr_o), 32'd7);
               check("dly_rd_wdata", rd_wdata_o, 32'h0000_9876);
               check("dly_stall_done", 32'(stall_o), 32'd0);
        tick(); mem_re_i = 1'b0;
        smp(); check("dly_rd_we_single", 32'(rd_we_o), 32'd0);

        // Grant never arrives: abort after 8 request cycles.
        tick(); set_req(1'b1, 1'b0, 32'h0000_5000, 32'd0, 2'b10, 1'b0, 5'd1);
        smp(); check("to_err_idle", 32'(err_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(); smp();
            check("to_req_wait", 32'(bif.bus_req_o), 32'd1);
            check("to_err_wait", 32'(err_o), 32'd0);
        end
        tick(); smp();
        check("to_err_pulse", 32'(err_o), 32'd1);
        check("to_req_drop", 32'(bif.bus_req_o), 32'd0);
        check("to_stall", 32'(stall_o), 32'd0);
        tick(); mem_re_i = 1'b0;
        smp(); check("to_err_end", 32'(err_o), 32'd0);
               check("to_req_idle", 32'(bif.bus_req_o), 32'd0);
               check("to_rd_we", 32'(rd_we_o), 32'd0);

        // Simultaneous read and write: read wins, err pulses once.
        tick(); set_req(1'b1, 1'b1, 32'h0000_6000, 32'h1111_2222, 2'b10, 1'b0, 5'd9);
        mem_waddr_i = 32'h0000_7000;
        smp(); check("both_err", 32'(err_o), 32'd1);
               check("both_stall", 32'(stall_o), 32'd1);
        tick(); bif.bus_gnt_i = 1'b1;
        smp(); check("both_we", 32'(bif.bus_we_o), 32'd0);
               check("both_addr", bif.bus_addr_o, 32'h0000_6000);
               check("both_err_end", 32'(err_o), 32'd0);
        tick(); bif.bus_gnt_i = 1'b0; bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'hDEAD_BEEF;
        smp();
        tick(); bif.bus_rvalid_i = 1'b0;
        smp(); check("both_rd_we", 32'(rd_we_o), 32'd1);
               check("both_rd_waddr", 32'(rd_waddr_o), 32'd9);
               check("both_rd_wdata", rd_wdata_o, 32'hDEAD_BEEF);
        tick(); mem_re_i = 1'b0; mem_we_i = 1'b0;

        // Reset while waiting for read data; late rvalid must be ignored.
        tick(); set_req(1'b1, 1'b0, 32'h0000_8000, 32'd0, 2'b10, 1'b0, 5'd4);
        smp();
        tick(); bif.bus_gnt_i = 1'b1;
        smp();
        tick(); bif.bus_gnt_i = 1'b0;
        smp(); check("rst_in_wait", 32'(stall_o), 32'd1);
        tick(); rst = 1'b0; mem_re_i = 1'b0;
        smp();
        tick(); rst = 1'b1; bif.bus_rvalid_i = 1'b1; bif.bus_rdata_i = 32'h0000_1234;
        smp(); check_all_zero("rst_wait");
        tick(); bif.bus_rvalid_i = 1'b0;
        smp(); check("rst_late_rd_we", 32'(rd_we_o), 32'd0);
               check("rst_late_err", 32'(err_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memctrl.md
MEMCTRL -- requirements
Module: memctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles a transaction waits in REQ or WAIT before abort.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-low.
REQ-004 SHALL have ports mem_re_i, mem_we_i  in  1 each  load/store request from execute stage, level, held while stall_o=1.
REQ-005 SHALL have ports mem_raddr_i, mem_waddr_i  in  32  byte addresses; mem_wdata_i  in  32  store data.
REQ-006 SHALL have ports byte_sel_i  in  2  (00 byte, 01 halfword, 10 word); un_sign_i  in  1  (1 = unsigned load); rd_waddr_i  in  5  load destination.
REQ-007 SHALL have bus ports bus_req_o  out  1; bus_we_o  out  1; bus_addr_o  out  32  word-aligned; bus_wdata_o  out  32; bus_wstrb_o  out  4.
REQ-008 SHALL have bus ports bus_gnt_i  in  1  request accepted; bus_rvalid_i  in  1  response (read data or write ack); bus_rdata_i  in  32.
REQ-009 SHALL have regfile ports rd_we_o  out  1; rd_waddr_o  out  5; rd_wdata_o  out  32.
REQ-010 SHALL have ports stall_o  out  1  pipeline hold; misalign_o  out  1; err_o  out  1.

Function
REQ-011 FSM states: IDLE, REQ, WAIT, DONE.
REQ-012 IDLE: if mem_re_i or mem_we_i and access aligned, latch address, data, byte_sel, un_sign, rd_waddr, direction; go to REQ.
REQ-013 If mem_re_i and mem_we_i are both 1, the read SHALL be taken, the write dropped, and err_o pulsed for 1 cycle.
REQ-014 Misaligned access (halfword with addr[0]=1; word with addr[1:0]!=0; byte_sel=11) SHALL issue no bus transaction, pulse misalign_o 1 cycle, cause no writeback, and stay in IDLE.
REQ-015 REQ: bus_req_o=1, bus_we_o, bus_addr_o={addr[31:2],2'b00}, bus_wdata_o and bus_wstrb_o all held stable until bus_gnt_i=1 is sampled; then go to WAIT.
REQ-016 bus_req_o SHALL drop in the cycle after the grant edge.
REQ-017 WAIT: on bus_rvalid_i=1, capture bus_rdata_i (loads) and go to DONE.
REQ-018 bus_rvalid_i sampled in REQ or IDLE SHALL be ignored.
REQ-019 DONE: lasts 1 cycle.
REQ-020 In DONE, for a load with rd_waddr!=0, rd_we_o=1 with rd_waddr_o/rd_wdata_o valid.
REQ-021 In DONE, for stores or rd_waddr=0, rd_we_o=0.
REQ-022 From DONE, next state is IDLE.
REQ-023 stall_o = (state is REQ or WAIT) or (state is IDLE and an aligned request is present); stall_o SHALL be 0 in DONE.
REQ-024 Load extraction: lane by addr[1:0] (byte) or addr[1] (halfword); sign-extend unless un_sign=1; word passes unchanged.
REQ-025 Store strobes: byte 4'b0001<<addr[1:0]; halfword 4'b0011<<addr[1:0]; word 4'b1111.
REQ-026 Store data: byte replicated {4{d[7:0]}}; halfword {2{d[15:0]}}; word d.
REQ-027 A counter SHALL reset on entering REQ and increment each cycle in REQ/WAIT.
REQ-028 When the counter reaches TIMEOUT_CYCLES without the awaited handshake: go to IDLE, drop bus_req_o, pulse err_o 1 cycle, no writeback, stall_o=0 that cycle.
REQ-029 Minimum load latency: request in IDLE cycle N, gnt at N+1, rvalid at N+2, rd_we_o at N+3.

Reset
REQ-030 While rst=0 at a clock edge: state := IDLE and counter := 0.
REQ-031 While rst=0 at a clock edge, all outputs SHALL be 0 from the next cycle: bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o, rd_we_o, rd_waddr_o, rd_wdata_o, stall_o, misalign_o, err_o.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no writeback and no err_o; late bus_rvalid_i after reset SHALL be ignored.

Verification
REQ-033 Byte load signed: mem_re_i, addr 0x1003, byte_sel 00, un_sign 0, rd 5; bus_rdata 0x80FF_1234 -> bus_addr 0x1000, rd_we_o with rd 5, data 0xFFFF_FF80, 3 cycles after request with 0-wait bus.
REQ-034 Halfword store: addr 0x2002, data 0x0000_ABCD -> bus_we_o=1, wstrb 4'b1100, wdata 0xABCD_ABCD, rd_we_o never 1.
REQ-035 Misaligned word load at 0x3001 -> misalign_o 1-cycle pulse, bus_req_o stays 0, stall_o 0.
REQ-036 Grant held off 4 cycles, then rvalid after 2 more cycles -> bus outputs stable throughout; stall_o high until DONE; single rd_we_o pulse.
REQ-037 TIMEOUT_CYCLES=8, no gnt -> abort after 8 cycles: err_o pulse, bus_req_o 0, FSM in IDLE.
REQ-038 Reset in WAIT, then rvalid -> no rd_we_o; all outputs 0.
